// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with illegal-op detect.
// Latency: lw 5, sw/R/imm 4, branch/jump 3 cycles; FETCH, MEMRD and MEMWR stall while mem_ready is low.
// Optional retired-instruction counter under macro INSTR_COUNT_EN.
module mips_multicycle_control #(
  parameter int ALU_CTRL_W    = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
`ifdef INSTR_COUNT_EN
  , parameter int COUNT_W     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  ext_zero,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic [3:0]            state,
  output logic                  illegal_op
`ifdef INSTR_COUNT_EN
  , output logic [COUNT_W-1:0]  instr_count
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(8);

  state_t                  state_q, state_d;
  logic                    mem_ok;
  logic                    funct_ok;
  logic [ALU_CTRL_W-1:0]   funct_alu;

  assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // funct is stable from DECODE onward, so ALUWB re-decodes it instead of latching EXEC's choice
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      6'h00:   funct_alu = ALU_SLL;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    ext_zero    = 1'b0;
    alu_control = '0;
    pc_src      = 2'd0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
        pc_en       = mem_ok;
        ir_write    = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b   = 2'd3;
        alu_control = ALU_ADD;
        case (opcode)
          OP_RTYPE:        state_d = S_EXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        alu_control = funct_alu;
        state_d     = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        ext_zero    = (opcode == OP_ANDI);
        alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        ext_zero  = (opcode == OP_ANDI);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'd1;
        pc_en       = (opcode == OP_BNE) ? ~zero : zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'd2;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // state is already FETCH during reset, whose enables would otherwise follow mem_ready
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

`ifdef INSTR_COUNT_EN
  logic retire;
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_IWB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEMWR) && mem_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + COUNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle scoreboard of expected states and controls.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control, state;
`ifdef INSTR_COUNT_EN
  logic [3:0] instr_count;
`endif

  always #5 clk = ~clk;

  mips_multicycle_control #(
    .ALU_CTRL_W(4), .MEM_HANDSHAKE(1'b1)
`ifdef INSTR_COUNT_EN
    , .COUNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_control(alu_control),
    .pc_src(pc_src), .state(state), .illegal_op(illegal_op)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  // fl = {pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal_op, ext_zero}
  typedef struct packed {
    logic [3:0] st;
    logic [9:0] fl;
    logic [3:0] alu;
    logic [1:0] pcs;
  } obs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       z;
  } stim_t;

  localparam logic [9:0] F_NONE  = 10'b0000000000;
  localparam logic [9:0] F_FETCH = 10'b1110000000;
  localparam logic [9:0] F_FWAIT = 10'b0010000000;
  localparam logic [9:0] F_ILL   = 10'b0000000010;
  localparam logic [9:0] F_ALUWB = 10'b0000011000;
  localparam logic [9:0] F_MEMRD = 10'b0010100000;
  localparam logic [9:0] F_MEMWB = 10'b0000010100;
  localparam logic [9:0] F_MEMWR = 10'b0001100000;
  localparam logic [9:0] F_EXTZ  = 10'b0000000001;
  localparam logic [9:0] F_IWBZ  = 10'b0000010001;
  localparam logic [9:0] F_IWB   = 10'b0000010000;
  localparam logic [9:0] F_PCEN  = 10'b1000000000;

  stim_t sq[$];
  obs_t  eq[$];
  stim_t s;
  obs_t  e, o;
  int    checks = 0;
  int    failures = 0;

  function automatic obs_t obs();
    obs_t r;
    r.st  = state;
    r.fl  = {pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
             illegal_op, ext_zero};
    r.alu = alu_control;
    r.pcs = pc_src;
    return r;
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic z, input logic [3:0] st, input logic [9:0] fl,
                      input logic [3:0] alu, input logic [1:0] pcs);
    sq.push_back({op, fn, rdy, z});
    eq.push_back({st, fl, alu, pcs});
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || {pc_en, ir_write, reg_write, mem_write} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold: got st=%0d en=%b want st=0 en=0000", state,
               {pc_en, ir_write, reg_write, mem_write});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== {4'd0, F_FWAIT, 4'd2, 2'd0}) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", o, {4'd0, F_FWAIT, 4'd2, 2'd0});
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    logic [3:0] alus[6] = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
    step(6'h00, 6'h20, 1'b0, 1'b0, 4'd0, F_FWAIT, 4'd2, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step(6'h00, fns[i], 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
      step(6'h00, fns[i], 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
      step(6'h00, fns[i], 1'b1, 1'b0, 4'd6, F_NONE, alus[i], 2'd0);
      step(6'h00, fns[i], 1'b1, 1'b0, 4'd7, F_ALUWB, alus[i], 2'd0);
    end
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rtype fn=%h: got st=%0d fl=%b alu=%0d pcs=%0d want st=%0d fl=%b alu=%0d pcs=%0d",
                 s.fn, o.st, o.fl, o.alu, o.pcs, e.st, e.fl, e.alu, e.pcs);
      end
    end
  endtask

  task automatic test_load_store();
    step(6'h23, 6'h00, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h23, 6'h00, 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h23, 6'h00, 1'b1, 1'b0, 4'd2, F_NONE, 4'd2, 2'd0);
    step(6'h23, 6'h00, 1'b0, 1'b0, 4'd3, F_MEMRD, 4'd0, 2'd0);
    step(6'h23, 6'h00, 1'b0, 1'b0, 4'd3, F_MEMRD, 4'd0, 2'd0);
    step(6'h23, 6'h00, 1'b1, 1'b0, 4'd3, F_MEMRD, 4'd0, 2'd0);
    step(6'h23, 6'h00, 1'b0, 1'b0, 4'd4, F_MEMWB, 4'd0, 2'd0);
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd2, F_NONE, 4'd2, 2'd0);
    step(6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, F_MEMWR, 4'd0, 2'd0);
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd5, F_MEMWR, 4'd0, 2'd0);
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ldst op=%h: got st=%0d fl=%b alu=%0d want st=%0d fl=%b alu=%0d",
                 s.op, o.st, o.fl, o.alu, e.st, e.fl, e.alu);
      end
    end
  endtask

  task automatic test_immediate();
    step(6'h0C, 6'h3F, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h0C, 6'h3F, 1'b0, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h0C, 6'h3F, 1'b0, 1'b0, 4'd8, F_EXTZ, 4'd5, 2'd0);
    step(6'h0C, 6'h3F, 1'b0, 1'b0, 4'd9, F_IWBZ, 4'd0, 2'd0);
    step(6'h08, 6'h3F, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h08, 6'h3F, 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h08, 6'h3F, 1'b1, 1'b0, 4'd8, F_NONE, 4'd2, 2'd0);
    step(6'h08, 6'h3F, 1'b1, 1'b0, 4'd9, F_IWB, 4'd0, 2'd0);
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL imm op=%h: got st=%0d fl=%b alu=%0d want st=%0d fl=%b alu=%0d",
                 s.op, o.st, o.fl, o.alu, e.st, e.fl, e.alu);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       zs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0] fls[4] = '{F_PCEN, F_NONE, F_NONE, F_PCEN};
    for (int i = 0; i < 4; i++) begin
      step(ops[i], 6'h00, 1'b1, zs[i], 4'd0, F_FETCH, 4'd2, 2'd0);
      step(ops[i], 6'h00, 1'b1, zs[i], 4'd1, F_NONE, 4'd2, 2'd0);
      step(ops[i], 6'h00, 1'b1, zs[i], 4'd10, fls[i], 4'd3, 2'd1);
    end
    step(6'h02, 6'h00, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h02, 6'h00, 1'b0, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h02, 6'h00, 1'b0, 1'b0, 4'd11, F_PCEN, 4'd0, 2'd2);
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL branch op=%h z=%b: got st=%0d fl=%b pcs=%0d want st=%0d fl=%b pcs=%0d",
                 s.op, s.z, o.st, o.fl, o.pcs, e.st, e.fl, e.pcs);
      end
    end
  endtask

  task automatic test_illegal();
    step(6'h3F, 6'h20, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h3F, 6'h20, 1'b0, 1'b0, 4'd1, F_ILL, 4'd2, 2'd0);
    step(6'h00, 6'h3F, 1'b1, 1'b0, 4'd0, F_FWAIT & 10'b0 | F_FETCH, 4'd2, 2'd0);
    step(6'h00, 6'h3F, 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h00, 6'h3F, 1'b1, 1'b0, 4'd6, F_ILL, 4'd2, 2'd0);
    step(6'h00, 6'h3F, 1'b0, 1'b0, 4'd0, F_FWAIT, 4'd2, 2'd0);
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal op=%h fn=%h: got st=%0d fl=%b want st=%0d fl=%b",
                 s.op, s.fn, o.st, o.fl, e.st, e.fl);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
    step(6'h2B, 6'h00, 1'b1, 1'b0, 4'd2, F_NONE, 4'd2, 2'd0);
    step(6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, F_MEMWR, 4'd0, 2'd0);
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_reset_setup: got st=%0d fl=%b want st=%0d fl=%b",
                 o.st, o.fl, e.st, e.fl);
      end
    end
    #2;
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (state !== 4'd0 || {pc_en, ir_write, reg_write, mem_write} !== 4'b0000) begin
        failures++;
        $display("FAIL mid_reset_%0d: got st=%0d en=%b want st=0 en=0000", k, state,
                 {pc_en, ir_write, reg_write, mem_write});
      end
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== {4'd0, F_FWAIT, 4'd2, 2'd0}) begin
      failures++;
      $display("FAIL mid_reset_release: got %h want %h", o, {4'd0, F_FWAIT, 4'd2, 2'd0});
    end
  endtask

`ifdef INSTR_COUNT_EN
  task automatic test_count();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (instr_count !== 4'd0) begin
      failures++;
      $display("FAIL count_reset: got %0d want 0", instr_count);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step(6'h02, 6'h00, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
      step(6'h02, 6'h00, 1'b1, 1'b0, 4'd1, F_NONE, 4'd2, 2'd0);
      step(6'h02, 6'h00, 1'b1, 1'b0, 4'd11, F_PCEN, 4'd0, 2'd2);
    end
    step(6'h3F, 6'h00, 1'b1, 1'b0, 4'd0, F_FETCH, 4'd2, 2'd0);
    step(6'h3F, 6'h00, 1'b0, 1'b0, 4'd1, F_ILL, 4'd2, 2'd0);
    while (eq.size() != 0) begin
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
      #1;
      e = eq.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL count_seq: got st=%0d fl=%b want st=%0d fl=%b", o.st, o.fl, e.st, e.fl);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (instr_count !== 4'd1) begin
      failures++;
      $display("FAIL count_wrap: got %0d want 1", instr_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_immediate();
    test_branch_jump();
    test_illegal();
    test_reset_mid_memwr();
`ifdef INSTR_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
